// File: rtl/sram_resp.sv
// sram_resp: memory-side responder for instruction-fetch and load/store ports.
// It accepts one request at a time and answers after LATENCY wait cycles from a
// word-addressed SRAM array that starts at byte address BASE.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    request present
//   req_ready    responder idle and able to accept (forced low while rst is high)
//   req_addr     byte address
//   req_wen      1 = write, 0 = read
//   req_wdata    write data
//   req_wmask    byte-lane write enables, bit i covers wdata[8i+7:8i]
//   resp_valid   response present
//   resp_ready   requester accepts the response
//   resp_rdata   read data; 0 for writes and errors
//   resp_err     misaligned or out-of-range address
module sram_resp #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE       = 32'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_wen,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam bit ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wen_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              wmask_q;
  logic                    err_q;
  logic                    rd_ok_q;
  logic [DATA_WIDTH-1:0]   rd_word_q;
  logic [DATA_WIDTH-1:0]   mem_q [0:(1<<DEPTH_LOG2)-1];

  logic                    enter_resp;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic                    c_wen;
  logic [DATA_WIDTH-1:0]   c_wdata;
  logic [3:0]              c_wmask;
  logic [ADDR_WIDTH-3:0]   c_word;
  logic                    c_err;
  logic [DEPTH_LOG2-1:0]   c_idx;
  logic [3:0]              lane_we;

  // With zero latency the commit happens on the accepting edge itself, so the
  // live request fields feed the array instead of the latched copy.
  assign c_addr  = ZERO_LAT ? req_addr  : addr_q;
  assign c_wen   = ZERO_LAT ? req_wen   : wen_q;
  assign c_wdata = ZERO_LAT ? req_wdata : wdata_q;
  assign c_wmask = ZERO_LAT ? req_wmask : wmask_q;

  // Word offset from BASE; anything above the array depth is out of range.
  assign c_word = c_addr[ADDR_WIDTH-1:2] - BASE[ADDR_WIDTH-1:2];
  assign c_idx  = c_word[DEPTH_LOG2-1:0];
  assign c_err  = (c_addr[1:0] != 2'b00) || (c_addr < BASE) ||
                  (c_word[ADDR_WIDTH-3:DEPTH_LOG2] != '0);

  // Reset must suppress any commit so an abandoned write never lands.
  assign commit = enter_resp && !rst;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
    assign lane_we[gi] = commit && c_wen && !c_err && c_wmask[gi];
  end

  assign req_ready  = !rst && (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rd_ok_q ? rd_word_q : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (ZERO_LAT) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        err_q   <= c_err;
        rd_ok_q <= !c_wen && !c_err;
      end
    end
  end

  // Request capture; the fields are only meaningful in the accept cycle.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      addr_q  <= req_addr;
      wen_q   <= req_wen;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  // Array with byte-lane writes and a registered read port; contents are
  // deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) mem_q[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
    end
    if (commit && !c_wen && !c_err) rd_word_q <= mem_q[c_idx];
  end

endmodule

// File: tb/tb_sram_resp.sv
module tb_sram_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          DL2  = 12;

  typedef struct {
    logic [31:0] addr;
    bit          wen;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with LATENCY = 2
  logic        req_valid = 0, req_ready, req_wen = 0, resp_valid, resp_ready = 0, resp_err;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata;
  logic [3:0]  req_wmask = 0;
  // DUT with LATENCY = 0
  logic        req_valid_z = 0, req_ready_z, req_wen_z = 0, resp_valid_z, resp_ready_z = 0, resp_err_z;
  logic [31:0] req_addr_z = 0, req_wdata_z = 0, resp_rdata_z;
  logic [3:0]  req_wmask_z = 0;

  sram_resp #(.LATENCY(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  sram_resp #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_addr(req_addr_z),
    .req_wen(req_wen_z), .req_wdata(req_wdata_z), .req_wmask(req_wmask_z),
    .resp_valid(resp_valid_z), .resp_ready(resp_ready_z),
    .resp_rdata(resp_rdata_z), .resp_err(resp_err_z)
  );

  int tests = 0;
  int fails = 0;

  exp_t q2[$];
  exp_t q0[$];
  exp_t e2, e0;
  logic [31:0] m2 [int unsigned];
  logic [31:0] m0 [int unsigned];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference memory: a word map addressed by (addr-BASE)/4.
  function automatic void model_op(input bit zl, input logic [31:0] a, input bit w,
                                   input logic [31:0] d, input logic [3:0] m,
                                   output logic [31:0] rd, output bit er);
    int unsigned word;
    logic [31:0] cur;
    er = (a % 4 != 0) || (a < BASE) || ((a - BASE) >= 32'(4 << DL2));
    rd = 32'h0;
    if (er) return;
    word = (a - BASE) / 4;
    if (w) begin
      cur = zl ? m0[word] : m2[word];
      for (int i = 0; i < 4; i++) if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
      if (zl) m0[word] = cur; else m2[word] = cur;
    end else begin
      rd = zl ? m0[word] : m2[word];
    end
  endfunction

  // Monitors: pop one expectation per response handshake.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (q2.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpected_resp_l2: got rdata %h err %0d expected no response", resp_rdata, resp_err);
      end else begin
        e2 = q2.pop_front();
        chk("l2_rdata", resp_rdata, e2.rdata);
        chk("l2_err", 32'(resp_err), 32'(e2.err));
        $display("[TB] L2 %s addr=%h rdata=%h err=%0d", e2.wen ? "WR" : "RD", e2.addr, resp_rdata, resp_err);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && resp_valid_z && resp_ready_z) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpected_resp_l0: got rdata %h err %0d expected no response", resp_rdata_z, resp_err_z);
      end else begin
        e0 = q0.pop_front();
        chk("l0_rdata", resp_rdata_z, e0.rdata);
        chk("l0_err", 32'(resp_err_z), 32'(e0.err));
        $display("[TB] L0 %s addr=%h rdata=%h err=%0d", e0.wen ? "WR" : "RD", e0.addr, resp_rdata_z, resp_err_z);
      end
    end
  end

  // One transaction on the LATENCY=2 instance; resp_ready is held low for
  // 'stall' cycles of resp_valid before being raised.
  task automatic send2(input logic [31:0] a, input bit w, input logic [31:0] d,
                       input logic [3:0] m, input int stall);
    exp_t        e;
    logic [31:0] r0;
    logic        er0;
    int          g;
    int          lat;
    e.addr = a;
    e.wen  = w;
    model_op(1'b0, a, w, d, m, e.rdata, e.err);
    q2.push_back(e);
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_addr   = a;
    req_wen    = w;
    req_wdata  = d;
    req_wmask  = m;
    resp_ready = (stall == 0);
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wmask = 4'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 40);
    chk("latency", 32'(lat), 32'd3);
    if (!resp_valid) return;
    r0  = resp_rdata;
    er0 = resp_err;
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        if (i > 0) begin
          @(negedge clk);
          chk("stall_valid", 32'(resp_valid), 32'd1);
          chk("stall_rdata", resp_rdata, r0);
          chk("stall_err", 32'(resp_err), 32'(er0));
        end
        chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("valid_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no end of test expected finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] zdat [6];
    int          acc [6];
    int          k, g;
    exp_t        ez;

    // Reset values on both instances.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_req_ready_z", 32'(req_ready_z), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);

    // Preload words 0..15 through the port.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      d = (i == 0) ? 32'hDEAD_BEEF : (i == 1) ? 32'hAABB_CCDD : $urandom;
      send2(BASE + 32'(4 * i), 1'b1, d, 4'hF, 0);
    end

    // Basic read, partial-lane write, error cases, stall.
    send2(BASE, 1'b0, 32'h0, 4'h0, 0);
    send2(BASE + 32'h4, 1'b1, 32'h1122_3344, 4'b0101, 0);
    send2(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 0);
    send2(BASE + 32'h2, 1'b0, 32'h0, 4'h0, 0);
    send2(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 0);
    send2(BASE + 32'h4000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0);
    send2(BASE, 1'b0, 32'h0, 4'h0, 0);
    send2(BASE + 32'h3, 1'b1, 32'hFFFF_FFFF, 4'hF, 0);
    send2(BASE + 32'h8, 1'b1, 32'h5555_5555, 4'h0, 0);
    send2(BASE + 32'h8, 1'b0, 32'h0, 4'h0, 5);

    // Randomized traffic within the preloaded window plus error addresses.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (sel == 1) a = $urandom & 32'h7FFF_FFFC;
      else if (sel == 2) a = BASE + 32'h4000 + 32'($urandom_range(0, 255) * 4);
      else               a = BASE + 32'($urandom_range(0, 15) * 4);
      send2(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3));
    end

    // Zero-latency instance: req_valid held high across six requests.
    for (int i = 0; i < 3; i++) zdat[i] = $urandom;
    @(posedge clk); #1;
    resp_ready_z = 1'b1;
    req_valid_z  = 1'b1;
    req_addr_z   = BASE;
    req_wen_z    = 1'b1;
    req_wdata_z  = zdat[0];
    req_wmask_z  = 4'hF;
    k = 0;
    g = 0;
    while (k < 6 && g < 100) begin
      @(negedge clk);
      g++;
      if (req_ready_z) begin
        acc[k]  = cyc;
        ez.addr = req_addr_z;
        ez.wen  = req_wen_z;
        model_op(1'b1, req_addr_z, req_wen_z, req_wdata_z, req_wmask_z, ez.rdata, ez.err);
        q0.push_back(ez);
        k++;
        @(posedge clk); #1;
        if (k < 6) begin
          req_addr_z  = BASE + 32'(4 * (k % 3));
          req_wen_z   = (k < 3);
          req_wdata_z = (k < 3) ? zdat[k] : $urandom;
        end else begin
          req_valid_z = 1'b0;
        end
      end
    end
    req_valid_z = 1'b0;
    chk("z_accept_count", 32'(k), 32'd6);
    for (int i = 1; i < k; i++) chk("z_accept_spacing", 32'(acc[i] - acc[i-1]), 32'd2);
    repeat (3) @(negedge clk);

    // Reset while BUSY during a write: the write must be abandoned.
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_addr   = BASE + 32'h10;
    req_wen    = 1'b1;
    req_wdata  = 32'hFFFF_FFFF;
    req_wmask  = 4'hF;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("rb_accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("rb_req_ready_in_rst", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rb_valid", 32'(resp_valid), 32'd0);
    chk("rb_rdata", resp_rdata, 32'd0);
    chk("rb_err", 32'(resp_err), 32'd0);
    chk("rb_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rb_no_resp", 32'(resp_valid), 32'd0);
    end
    send2(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 0);

    repeat (3) @(negedge clk);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
